// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and general register file.
// Picks the write-back value (jal link PC, load data or ALU result) and commits
// it to a 2^ASIZE-entry register file. Register 0 always reads as zero.
// Two combinational read ports use write-first bypass, so a value being written
// is visible on the read ports in the same cycle.
// commit_cnt is a wrapping count of committed (non-dropped) writes.
module wb_regfile #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5,
    parameter int ISIZE = 32,
    parameter int CSIZE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen_in,
    input  logic [ASIZE-1:0] w_addr_in,
    input  logic [DSIZE-1:0] w_data_in,
    input  logic [DSIZE-1:0] readMem_in,
    input  logic             MemtoReg_in,
    input  logic             jal_in,
    input  logic [ISIZE-1:0] PC_in,
    input  logic [ASIZE-1:0] r_addr1,
    input  logic [ASIZE-1:0] r_addr2,
    output logic [DSIZE-1:0] r_data1,
    output logic [DSIZE-1:0] r_data2,
    output logic [CSIZE-1:0] commit_cnt
);

    localparam int               DEPTH = 1 << ASIZE;
    localparam logic [ASIZE-1:0] LINK  = '1;

    logic [DSIZE-1:0] regs_q [DEPTH];
    logic [DSIZE-1:0] regs_d [DEPTH];
    logic [CSIZE-1:0] cnt_q;
    logic [CSIZE-1:0] cnt_d;

    logic [DSIZE-1:0] pc_ext;
    logic [DSIZE-1:0] wb_data;
    logic [ASIZE-1:0] wb_addr;
    logic             commit;

    // Fit the link PC to the register width.
    generate
        if (ISIZE >= DSIZE) begin : g_pc_trunc
            assign pc_ext = PC_in[DSIZE-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DSIZE-ISIZE){1'b0}}, PC_in};
        end
    endgenerate

    // Write-back select; commits are suppressed while reset is held, which also
    // keeps the bypass from showing anything but zero during reset.
    always_comb begin
        wb_addr = w_addr_in;
        wb_data = w_data_in;
        if (jal_in) begin
            wb_addr = LINK;
            wb_data = pc_ext;
        end else if (MemtoReg_in) begin
            wb_data = readMem_in;
        end
        commit = rst & (wen_in | jal_in) & (wb_addr != '0);
    end

    // Next state of the register array and the commit counter.
    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[wb_addr] = wb_data;
        end
        regs_d[0] = '0;
        cnt_d = cnt_q + {{(CSIZE-1){1'b0}}, commit};
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: write-first bypass, otherwise the stored entry (entry 0 stays zero).
    always_comb begin
        r_data1 = (commit && (r_addr1 == wb_addr)) ? wb_data : regs_q[r_addr1];
        r_data2 = (commit && (r_addr2 == wb_addr)) ? wb_data : regs_q[r_addr2];
    end

    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile (CSIZE=4 so the commit counter wraps quickly).
// Directed steps from the register-file behaviour, then a randomized run, all
// compared against an array-based reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen_in;
    logic [4:0]  w_addr_in;
    logic [31:0] w_data_in;
    logic [31:0] readMem_in;
    logic        MemtoReg_in;
    logic        jal_in;
    logic [31:0] PC_in;
    logic [4:0]  r_addr1;
    logic [4:0]  r_addr2;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    logic [3:0]  commit_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [32];
    int          mcnt;

    wb_regfile #(.DSIZE(32), .ASIZE(5), .ISIZE(32), .CSIZE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wen_in      (wen_in),
        .w_addr_in   (w_addr_in),
        .w_data_in   (w_data_in),
        .readMem_in  (readMem_in),
        .MemtoReg_in (MemtoReg_in),
        .jal_in      (jal_in),
        .PC_in       (PC_in),
        .r_addr1     (r_addr1),
        .r_addr2     (r_addr2),
        .r_data1     (r_data1),
        .r_data2     (r_data2),
        .commit_cnt  (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: value chosen for write-back and whether it lands anywhere.
    function automatic logic [31:0] sel_data();
        if (jal_in)      return PC_in;
        if (MemtoReg_in) return readMem_in;
        return w_data_in;
    endfunction

    function automatic int sel_addr();
        return jal_in ? 31 : int'(w_addr_in);
    endfunction

    function automatic bit writes_now();
        return (rst === 1'b1) && (wen_in || jal_in) && (sel_addr() != 0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (writes_now() && int'(a) == sel_addr()) return sel_data();
        return mdl[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcnt = 0;
    endtask

    task automatic model_edge();
        if (writes_now()) begin
            mdl[sel_addr()] = sel_data();
            mcnt = (mcnt + 1) % 16;
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, ".rd1"}, r_data1, exp_read(r_addr1));
        check({tag, ".rd2"}, r_data2, exp_read(r_addr2));
    endtask

    task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] rm, input logic m2r, input logic jal,
                         input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2);
        wen_in = wen; w_addr_in = wa; w_data_in = wd; readMem_in = rm;
        MemtoReg_in = m2r; jal_in = jal; PC_in = pc; r_addr1 = ra1; r_addr2 = ra2;
    endtask

    // One cycle: check reads before the edge, clock, then check counter and reads.
    task automatic step(input string tag);
        #1;
        check_reads({tag, ".pre"});
        @(posedge clk);
        model_edge();
        #2;
        check({tag, ".cnt"}, {28'h0, commit_cnt}, mcnt[31:0]);
        check_reads({tag, ".post"});
    endtask

    initial begin
        rst = 1'b0;
        model_clear();
        // Reset held with a write pending: nothing lands, all reads zero.
        drive(1'b1, 5'd3, 32'hDEAD, 32'h0, 1'b0, 1'b0, 32'h0, 5'd3, 5'd3);
        repeat (2) @(posedge clk);
        #2;
        for (int a = 0; a < 32; a++) begin
            r_addr1 = 5'(a);
            #1;
            check("reset_read", r_data1, 32'h0);
        end
        check("reset_cnt", {28'h0, commit_cnt}, 32'h0);
        r_addr1 = 5'd3;
        rst = 1'b1;
        step("first_commit");
        check("reg3_model", mdl[3], 32'hDEAD);
        drive(1'b0, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd3, 5'd0);
        step("reg3_hold");

        // Write-back select.
        drive(1'b1, 5'd7, 32'h5678, 32'h1234, 1'b1, 1'b0, 32'h0, 5'd7, 5'd3);
        step("sel_mem");
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd7, 5'd7);
        #1; check("sel_mem_val", r_data1, 32'h1234);
        step("sel_mem_rd");
        drive(1'b1, 5'd7, 32'h5678, 32'h1234, 1'b0, 1'b0, 32'h0, 5'd7, 5'd0);
        step("sel_alu");
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd7, 5'd7);
        #1; check("sel_alu_val", r_data1, 32'h5678);

        // jal writes LINK with wen low; also jal beats MemtoReg.
        drive(1'b0, 5'd4, 32'h99, 32'h77, 1'b1, 1'b1, 32'h40, 5'd31, 5'd4);
        step("jal");
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd31, 5'd4);
        #1; check("jal_link", r_data1, 32'h40);
        check("jal_reg4", r_data2, 32'h0);
        check("jal_cnt", {28'h0, commit_cnt}, 32'd4);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h88, 5'd31, 5'd0);
        step("jal_addr0");

        // Zero register: write dropped, not counted, reads zero this and next cycle.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);
        #1; check("zero_pre", r_data1, 32'h0);
        step("zero_wr");
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);
        step("zero_next");
        check("zero_cnt", {28'h0, commit_cnt}, 32'd5);

        // Bypass on both ports.
        drive(1'b1, 5'd9, 32'h11, 32'h0, 1'b0, 1'b0, 32'h0, 5'd9, 5'd9);
        step("byp_seed");
        drive(1'b1, 5'd9, 32'h22, 32'h0, 1'b0, 1'b0, 32'h0, 5'd9, 5'd9);
        #1; check("byp_pre1", r_data1, 32'h22);
        check("byp_pre2", r_data2, 32'h22);
        step("byp");
        check("byp_post1", r_data1, 32'h22);

        // Async reset mid-cycle, then 17 commits wrap the 4-bit counter to 1.
        #1; rst = 1'b0; #1;
        model_clear();
        check("async_cnt", {28'h0, commit_cnt}, 32'h0);
        check_reads("async_rd");
        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'(1 + (i % 31)), $urandom, 32'h0, 1'b0, 1'b0, 32'h0, 5'(i), 5'd9);
            step("wrap_seq");
        end
        check("wrap_cnt", {28'h0, commit_cnt}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive(($urandom % 4) != 0, wa, $urandom, $urandom, 1'($urandom % 2),
                  ($urandom % 8) == 0, $urandom,
                  (($urandom % 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  (($urandom % 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)));
            step("rand");
            if (i == 150) begin
                #1; rst = 1'b0; #1;
                model_clear();
                check("rand_rst_cnt", {28'h0, commit_cnt}, 32'h0);
                @(negedge clk);
                rst = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
